udp_payload_router: RTL and testbench

- Parametrised successor to the single-channel UDP payload extractor. Consumes the 8-bit MAC RX stream, filters Ethernet/IPv4/UDP headers and the magic signature, and steers the payload to one of NUM_CH logical channels by UDP destination port.
- Uses store-and-forward with commit/rollback, so downstream (order book ingress) only ever sees complete, validated payloads. Ethernet padding is trimmed using the UDP length field.
- Sits between the MAC RX and the per-channel order-book decoders.

---
 rtl/udp_rx_pkg.sv | 39 +++
 rtl/pkt_commit_fifo.sv | 59 +++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/udp_payload_router.sv | 268 ++++++++++++++++++++++++++
 tb/tb_udp_payload_router.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_rx_pkg.sv
// udp_rx_pkg
// Shared constants and types for the UDP RX payload path.
//   - Byte offsets of the header fields inside an Ethernet/IPv4/UDP frame
//     (no VLAN tag, IHL = 5).
//   - Parser state encoding.
//   - clog2 helper for sizing channel ids.
package udp_rx_pkg;

  localparam int ETYPE_OFF   = 12;
  localparam int VIHL_OFF    = 14;
  localparam int PROTO_OFF   = 23;
  localparam int DIP_OFF     = 30;
  localparam int SPORT_OFF   = 34;
  localparam int DPORT_OFF   = 36;
  localparam int ULEN_OFF    = 38;
  localparam int PAYLOAD_OFF = 42;
  localparam int MAGIC_LEN   = 3;

  // UDP length covers the 8-byte UDP header plus the magic, neither of
  // which is forwarded downstream.
  localparam int UDP_OVERHEAD = 8 + MAGIC_LEN;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_MAGIC   = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PAD     = 3'd4,
    ST_DROP    = 3'd5
  } parse_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/pkt_commit_fifo.sv
// pkt_commit_fifo
// Byte buffer with speculative writes. Bytes of the frame being parsed are
// written at wr_spec; the reader only ever consumes up to wr_com, which
// advances on commit. Rollback rewinds wr_spec to wr_com, discarding the
// partial frame.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, wr_data      speculative byte write (ignored when full)
//   commit              wr_com <= wr_spec
//   rollback            wr_spec <= wr_com
//   rd_en               advance read pointer
//   rd_data             byte at the read pointer
//   full                one free slot left (kept empty to tell full from empty)
module pkt_commit_fifo #(
  parameter int AW = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_spec;
  logic [AW-1:0] wr_com;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;

  assign full    = ((wr_spec + AW'(1)) == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_spec] <= wr_data;
  end

  // The parser never writes on a commit/rollback cycle (the next frame is
  // still in its header), so rollback simply takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_spec <= '0;
      wr_com  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (rollback)   wr_spec <= wr_com;
      else if (do_wr) wr_spec <= wr_spec + AW'(1);
      if (commit) wr_com <= wr_spec;
      if (rd_en)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Plain single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write request / data (ignored when full)
//   pop                 read request (ignored when empty)
//   pop_data            head entry, valid whenever empty is low
//   full, empty         occupancy flags
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/udp_payload_router.sv
// udp_payload_router
// Parses the MAC RX byte stream, keeps only IPv4/UDP frames to DEST_IP from
// SRC_PORT carrying the MAGIC signature, and forwards the payload (magic
// stripped, Ethernet padding trimmed by UDP length) on channel
// udp_dst_port - BASE_PORT. Payloads are stored and only released once the
// whole frame has been validated.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast  RX bytes, no backpressure
//   m_axis_tdata/tvalid/tready/tlast/tdest  payload stream per packet
//   cnt_ok, cnt_drop, cnt_ovf  saturating packet counters
//   dbg_state                parser state (parse_state_t encoding)
//
// Output handshake: a beat transfers on a cycle where m_axis_tvalid and
// m_axis_tready are both high. Once tvalid is raised, tvalid, tdata, tdest
// and tlast hold their values until that transfer happens.
module udp_payload_router
  import udp_rx_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [15:0] BASE_PORT = 16'd60000,
  parameter logic [31:0] DEST_IP   = {8'd192, 8'd168, 8'd1, 8'd50},
  parameter logic [15:0] SRC_PORT  = 16'd55555,
  parameter logic [23:0] MAGIC     = 24'h670420,
  parameter int          BUF_AW    = 11,
  parameter int          META_AW   = 3,
  localparam int         CH_W      = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  output logic [7:0]      m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic [CH_W-1:0] m_axis_tdest,
  output logic [15:0]     cnt_ok,
  output logic [15:0]     cnt_drop,
  output logic [15:0]     cnt_ovf,
  output logic [2:0]      dbg_state
);

  // ---------------- parser ----------------
  parse_state_t    state_q, state_d;
  logic [10:0]     byte_cnt;
  logic [7:0]      prev_byte;
  logic [15:0]     plen_q;
  logic [15:0]     pay_cnt;
  logic [CH_W-1:0] ch_q;
  logic            ovf_q;

  logic [15:0] field16;
  logic [15:0] dport_off;
  logic        mismatch;
  logic        buf_wr;
  logic        buf_full;
  logic        hit_full;
  logic        pay_last;
  logic        frame_ok_now;
  logic        frame_ovf_now;

  logic dec_valid, dec_good, dec_ovf;

  assign dbg_state = state_q;
  // Two-byte fields end on the current byte; the high byte is prev_byte.
  assign field16   = {prev_byte, s_axis_tdata};
  assign dport_off = field16 - BASE_PORT;

  // Per-offset field check; only consulted in HDR and MAGIC.
  always_comb begin
    mismatch = 1'b0;
    case (byte_cnt)
      11'(ETYPE_OFF):       mismatch = (s_axis_tdata != 8'h08);
      11'(ETYPE_OFF + 1):   mismatch = (s_axis_tdata != 8'h00);
      11'(VIHL_OFF):        mismatch = (s_axis_tdata != 8'h45);
      11'(PROTO_OFF):       mismatch = (s_axis_tdata != 8'h11);
      11'(DIP_OFF):         mismatch = (s_axis_tdata != DEST_IP[31:24]);
      11'(DIP_OFF + 1):     mismatch = (s_axis_tdata != DEST_IP[23:16]);
      11'(DIP_OFF + 2):     mismatch = (s_axis_tdata != DEST_IP[15:8]);
      11'(DIP_OFF + 3):     mismatch = (s_axis_tdata != DEST_IP[7:0]);
      11'(SPORT_OFF):       mismatch = (s_axis_tdata != SRC_PORT[15:8]);
      11'(SPORT_OFF + 1):   mismatch = (s_axis_tdata != SRC_PORT[7:0]);
      11'(DPORT_OFF + 1):   mismatch = (dport_off >= 16'(NUM_CH));
      11'(ULEN_OFF + 1):    mismatch = (field16 <= 16'(UDP_OVERHEAD));
      11'(PAYLOAD_OFF):     mismatch = (s_axis_tdata != MAGIC[23:16]);
      11'(PAYLOAD_OFF + 1): mismatch = (s_axis_tdata != MAGIC[15:8]);
      11'(PAYLOAD_OFF + 2): mismatch = (s_axis_tdata != MAGIC[7:0]);
      default:              mismatch = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    buf_wr   = 1'b0;
    hit_full = 1'b0;
    pay_last = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        ST_IDLE: state_d = ST_HDR;
        ST_HDR: begin
          if (mismatch) state_d = ST_DROP;
          else if (byte_cnt == 11'(PAYLOAD_OFF - 1)) state_d = ST_MAGIC;
        end
        ST_MAGIC: begin
          if (mismatch) state_d = ST_DROP;
          else if (byte_cnt == 11'(PAYLOAD_OFF + MAGIC_LEN - 1)) state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (buf_full) begin
            // Out of buffer: abandon the frame, counted as overflow.
            hit_full = 1'b1;
            state_d  = ST_DROP;
          end else begin
            buf_wr = 1'b1;
            if (pay_cnt == plen_q - 16'd1) begin
              pay_last = 1'b1;
              state_d  = ST_PAD;
            end
          end
        end
        ST_PAD:  state_d = ST_PAD;
        ST_DROP: state_d = ST_DROP;
        default: state_d = ST_DROP;
      endcase
      if (s_axis_tlast) state_d = ST_IDLE;
    end
  end

  // Verdict of a frame ending on this beat: complete payload, or overflow.
  assign frame_ok_now  = (state_q == ST_PAD) || pay_last;
  assign frame_ovf_now = ovf_q || hit_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      byte_cnt  <= '0;
      prev_byte <= '0;
      plen_q    <= '0;
      pay_cnt   <= '0;
      ch_q      <= '0;
      ovf_q     <= 1'b0;
      dec_valid <= 1'b0;
      dec_good  <= 1'b0;
      dec_ovf   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dec_valid <= s_axis_tvalid && s_axis_tlast;
      dec_good  <= frame_ok_now;
      dec_ovf   <= frame_ovf_now;
      if (s_axis_tvalid) begin
        prev_byte <= s_axis_tdata;
        if (s_axis_tlast)              byte_cnt <= '0;
        else if (byte_cnt != 11'h7FF)  byte_cnt <= byte_cnt + 11'd1;
        if (state_q == ST_IDLE) begin
          pay_cnt <= '0;
          ovf_q   <= 1'b0;
        end
        if (buf_wr)   pay_cnt <= pay_cnt + 16'd1;
        if (hit_full) ovf_q   <= 1'b1;
        // ch_q/plen_q stay valid through the decision cycle: the next frame
        // cannot reach these offsets that soon.
        if (byte_cnt == 11'(DPORT_OFF + 1)) ch_q   <= dport_off[CH_W-1:0];
        if (byte_cnt == 11'(ULEN_OFF + 1))  plen_q <= field16 - 16'(UDP_OVERHEAD);
      end
    end
  end

  // ---------------- commit / rollback ----------------
  logic                 meta_full, meta_empty, meta_push, meta_pop;
  logic [CH_W+15:0]     meta_rdata;
  logic                 commit, rollback;
  logic                 inc_ok, inc_drop, inc_ovf;

  assign commit    = dec_valid && dec_good && !meta_full;
  assign rollback  = dec_valid && !commit;
  assign meta_push = commit;
  assign inc_ok    = commit;
  assign inc_ovf   = dec_valid && (dec_ovf || (dec_good && meta_full));
  assign inc_drop  = dec_valid && !dec_good && !dec_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok   <= '0;
      cnt_drop <= '0;
      cnt_ovf  <= '0;
    end else begin
      if (inc_ok   && cnt_ok   != 16'hFFFF) cnt_ok   <= cnt_ok   + 16'd1;
      if (inc_drop && cnt_drop != 16'hFFFF) cnt_drop <= cnt_drop + 16'd1;
      if (inc_ovf  && cnt_ovf  != 16'hFFFF) cnt_ovf  <= cnt_ovf  + 16'd1;
    end
  end

  // ---------------- storage ----------------
  logic       rd_en;
  logic [7:0] rd_data;

  pkt_commit_fifo #(.AW(BUF_AW)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr),
    .wr_data  (s_axis_tdata),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (buf_full)
  );

  sync_fifo #(.W(CH_W + 16), .AW(META_AW)) u_meta (
    .clk       (clk),
    .rst       (rst),
    .push      (meta_push),
    .push_data ({ch_q, plen_q}),
    .pop       (meta_pop),
    .pop_data  (meta_rdata),
    .full      (meta_full),
    .empty     (meta_empty)
  );

  // ---------------- output ----------------
  logic            out_active;
  logic [15:0]     out_rem;
  logic [CH_W-1:0] out_ch;
  logic            load;
  logic            emit;
  logic            last_byte;

  assign load      = !m_axis_tvalid || m_axis_tready;
  assign emit      = load && out_active;
  assign last_byte = (out_rem == 16'd1);
  assign rd_en     = emit;
  // Fetch the next packet's metadata while the current last byte is being
  // loaded, so consecutive packets stream without a bubble.
  assign meta_pop  = !meta_empty && (!out_active || (emit && last_byte));

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
      out_active    <= 1'b0;
      out_rem       <= '0;
      out_ch        <= '0;
    end else begin
      if (load) begin
        m_axis_tvalid <= emit;
        if (emit) begin
          m_axis_tdata <= rd_data;
          m_axis_tlast <= last_byte;
          m_axis_tdest <= out_ch;
        end
      end
      if (emit) begin
        out_rem <= out_rem - 16'd1;
        if (last_byte) out_active <= 1'b0;
      end
      if (meta_pop) begin
        out_active <= 1'b1;
        out_rem    <= meta_rdata[15:0];
        out_ch     <= meta_rdata[CH_W+15:16];
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_router.sv
module tb_udp_payload_router;
  import udp_rx_pkg::*;

  localparam int          NUM_CH    = 4;
  localparam int          CH_W      = 2;
  localparam int          BUF_AW    = 6;
  localparam int          BUF_FREE  = (1 << BUF_AW) - 1;
  localparam logic [15:0] BASE_PORT = 16'd60000;
  localparam logic [31:0] DEST_IP   = {8'd192, 8'd168, 8'd1, 8'd50};
  localparam logic [15:0] SRC_PORT  = 16'd55555;
  localparam logic [23:0] MAGIC     = 24'h670420;

  logic            clk, rst;
  logic [7:0]      s_axis_tdata;
  logic            s_axis_tvalid, s_axis_tlast;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [CH_W-1:0] m_axis_tdest;
  logic [15:0]     cnt_ok, cnt_drop, cnt_ovf;
  logic [2:0]      dbg_state;

  udp_payload_router #(
    .NUM_CH(NUM_CH), .BASE_PORT(BASE_PORT), .DEST_IP(DEST_IP),
    .SRC_PORT(SRC_PORT), .MAGIC(MAGIC), .BUF_AW(BUF_AW), .META_AW(3)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop), .cnt_ovf(cnt_ovf), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int exp_ok = 0, exp_drop = 0, exp_ovf = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: alternate
  logic [10:0] exp_q[$];    // {tdest, tlast, tdata}
  logic [7:0]  frame_q[$];
  logic [7:0]  pay_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      m_axis_tready = 1'b1;
      else if (ready_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
      else                      m_axis_tready = !m_axis_tready;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat  = '0;
  always @(negedge clk) begin
    logic [10:0] got;
    logic [10:0] e;
    got = {m_axis_tdest, m_axis_tlast, m_axis_tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (!m_axis_tvalid || got !== prev_beat) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b beat=%0h expected v=1 beat=%0h", m_axis_tvalid, got, prev_beat);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no output", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL beat: got dest/last/data %0h expected %0h", got, e);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = got;
    end
  end

  // ---------------- frame construction ----------------
  task automatic rand_payload(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic build_frame(input logic [15:0] sport, input logic [15:0] dport,
                             input logic [15:0] ulen, input int min_len);
    frame_q.delete();
    for (int i = 0; i < 12; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(8'h08); frame_q.push_back(8'h00); frame_q.push_back(8'h45);
    for (int i = 15; i < 23; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(8'h11);
    for (int i = 24; i < 30; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(DEST_IP[31:24]); frame_q.push_back(DEST_IP[23:16]);
    frame_q.push_back(DEST_IP[15:8]);  frame_q.push_back(DEST_IP[7:0]);
    frame_q.push_back(sport[15:8]); frame_q.push_back(sport[7:0]);
    frame_q.push_back(dport[15:8]); frame_q.push_back(dport[7:0]);
    frame_q.push_back(ulen[15:8]);  frame_q.push_back(ulen[7:0]);
    frame_q.push_back(8'($urandom)); frame_q.push_back(8'($urandom));
    frame_q.push_back(MAGIC[23:16]); frame_q.push_back(MAGIC[15:8]); frame_q.push_back(MAGIC[7:0]);
    foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
    while (frame_q.size() < min_len) frame_q.push_back(8'h00);
  endtask

  task automatic make_good(input int plen, input int ch, input int min_len);
    rand_payload(plen);
    build_frame(SRC_PORT, BASE_PORT + 16'(ch), 16'(plen + 11), min_len);
  endtask

  // Reference model: decides the fate of frame_q from the filtering rules and
  // queues the expected payload beats. free = buffer bytes available.
  task automatic model_frame(input int free);
    int n, plen;
    logic ok;
    logic [15:0] dport_off, ulen;
    n = frame_q.size();
    ok = 1'b0; plen = 0; dport_off = '0; ulen = '0;
    if (n >= 45) begin
      dport_off = {frame_q[36], frame_q[37]} - BASE_PORT;
      ulen      = {frame_q[38], frame_q[39]};
      ok = frame_q[12] == 8'h08 && frame_q[13] == 8'h00 && frame_q[14] == 8'h45
        && frame_q[23] == 8'h11
        && {frame_q[30], frame_q[31], frame_q[32], frame_q[33]} == DEST_IP
        && {frame_q[34], frame_q[35]} == SRC_PORT
        && dport_off < 16'(NUM_CH) && ulen > 16'd11
        && {frame_q[42], frame_q[43], frame_q[44]} == MAGIC;
    end
    if (!ok) exp_drop++;
    else begin
      plen = int'(ulen) - 11;
      if (plen > free && n > 45 + free) exp_ovf++;
      else if (n >= 45 + plen) begin
        exp_ok++;
        for (int k = 0; k < plen; k++)
          exp_q.push_back({dport_off[CH_W-1:0], (k == plen - 1), frame_q[45 + k]});
      end else exp_drop++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_n(input int n, input logic mark_last);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = frame_q[i];
      s_axis_tlast  = mark_last && (i == n - 1);
    end
  endtask

  task automatic send_frame();
    send_n(frame_q.size(), 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 8'h00;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      idle(1);
      t++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    idle(10);
  endtask

  task automatic check_counters(input string name);
    check({name, "_cnt_ok"},   cnt_ok,   16'(exp_ok));
    check({name, "_cnt_drop"}, cnt_drop, 16'(exp_drop));
    check({name, "_cnt_ovf"},  cnt_ovf,  16'(exp_ovf));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kind, plen, gap;
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata",  m_axis_tdata, 0);
    check("rst_tlast",  m_axis_tlast, 0);
    check("rst_tdest",  m_axis_tdest, 0);
    check_counters("rst");
    check("rst_state",  dbg_state, 32'(ST_IDLE));
    rst = 1'b0;
    idle(3);

    // Known frame: dport 60002, udp_len 16, payload AA..EE.
    pay_q.delete();
    pay_q.push_back(8'hAA); pay_q.push_back(8'hBB); pay_q.push_back(8'hCC);
    pay_q.push_back(8'hDD); pay_q.push_back(8'hEE);
    build_frame(SRC_PORT, 16'd60002, 16'd16, 0);
    model_frame(BUF_FREE);
    check("t1_expected_beats", exp_q.size(), 5);
    send_frame(); idle(1);
    wait_drain("t1");
    check_counters("t1");

    // Padded 60-byte frame, udp_len 13 -> 2 bytes.
    make_good(2, 1, 60);
    check("t2_frame_len", frame_q.size(), 60);
    model_frame(BUF_FREE);
    send_frame(); idle(1);
    wait_drain("t2");
    check_counters("t2");

    // Filtered frames: wrong sport, bad magic byte 44, dport 60004.
    rand_payload(6); build_frame(16'd55556, BASE_PORT, 16'd17, 0);
    model_frame(BUF_FREE); send_frame(); idle(4);
    make_good(6, 3, 0); frame_q[44] = frame_q[44] ^ 8'h01;
    model_frame(BUF_FREE); send_frame(); idle(4);
    rand_payload(6); build_frame(SRC_PORT, 16'd60004, 16'd17, 0);
    model_frame(BUF_FREE); send_frame(); idle(1);
    wait_drain("t3");
    check_counters("t3");

    // Truncated frame then a back-to-back good frame.
    make_good(9, 0, 0);
    while (frame_q.size() > 48) void'(frame_q.pop_back());
    model_frame(BUF_FREE); send_frame();
    make_good(7, 2, 0);
    model_frame(BUF_FREE); send_frame(); idle(1);
    wait_drain("t4");
    check_counters("t4");

    // Payload larger than the buffer, then a 10-byte payload.
    make_good(100, 1, 0);
    model_frame(BUF_FREE); send_frame(); idle(2);
    make_good(10, 3, 0);
    model_frame(BUF_FREE); send_frame(); idle(1);
    wait_drain("t5");
    check_counters("t5");

    // Three back-to-back frames with alternating ready.
    ready_mode = 2;
    make_good(7, 0, 0);  model_frame(BUF_FREE); send_frame();
    make_good(12, 3, 0); model_frame(BUF_FREE); send_frame();
    make_good(9, 1, 0);  model_frame(BUF_FREE); send_frame(); idle(1);
    wait_drain("t6");
    check_counters("t6");

    // Randomized frames with random corruptions and random ready.
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      plen = $urandom_range(1, 20);
      make_good(plen, $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 60 : 0);
      kind = $urandom_range(0, 15);
      case (kind)
        1: frame_q[12] = 8'h86;
        2: frame_q[14] = 8'h46;
        3: frame_q[23] = 8'h06;
        4: frame_q[30 + $urandom_range(0, 3)] = frame_q[33] ^ 8'h5A;
        5: frame_q[35] = frame_q[35] ^ 8'h01;
        6: begin
          frame_q[36] = 8'hEA; frame_q[37] = 8'($urandom_range(100, 255));
        end
        7: frame_q[42 + $urandom_range(0, 2)] = 8'hFF;
        8: begin
          frame_q[38] = 8'h00; frame_q[39] = 8'($urandom_range(0, 11));
        end
        9: begin
          gap = $urandom_range(1, frame_q.size() - 1);
          while (frame_q.size() > gap) void'(frame_q.pop_back());
        end
        default: ;
      endcase
      model_frame(BUF_FREE);
      send_frame();
      gap = $urandom_range(0, 3);
      if (gap != 0) idle(gap);
    end
    idle(1);
    wait_drain("rand");
    check_counters("rand");

    // Reset while a packet streams out and another is being received.
    ready_mode = 0;
    make_good(40, 2, 0); model_frame(BUF_FREE); send_frame();
    make_good(10, 1, 0); send_n(20, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    exp_q.delete();
    exp_ok = 0; exp_drop = 0; exp_ovf = 0;
    @(posedge clk);
    #1;
    check("mrst_tvalid", m_axis_tvalid, 0);
    check("mrst_tdata",  m_axis_tdata, 0);
    check("mrst_tlast",  m_axis_tlast, 0);
    check("mrst_tdest",  m_axis_tdest, 0);
    check("mrst_state",  dbg_state, 32'(ST_IDLE));
    check_counters("mrst");
    rst = 1'b0;
    idle(60);
    check_counters("post_rst");

    make_good(5, 3, 0); model_frame(BUF_FREE); send_frame(); idle(1);
    wait_drain("final");
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
